// File: rtl/pulse_cdc_src_pkg.sv
// Shared definitions for the toggle-based pulse crossing: launcher FSM encoding
// and the default ack synchroniser depth shared with the destination synchroniser.
package pulse_cdc_src_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_state_e;

    localparam int PULSE_CDC_NUM_STAGES = 2;

endpackage

// File: rtl/pulse_cdc_src_ack_sync.sv
// Resynchronises the destination's ack toggle into clk and flags each level change.
// ack_edge is decoded from the two oldest stages so it is glitch-free and one cycle wide.
module pulse_cdc_ack_sync
    import pulse_cdc_src_pkg::*;
#(
    parameter int NUM_STAGES = PULSE_CDC_NUM_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic ack_toggle_in,
    output logic ack_edge
);

    logic [NUM_STAGES:0] ack_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[NUM_STAGES-1:0], ack_toggle_in};
        end
    end

    assign ack_edge = ack_sync[NUM_STAGES] ^ ack_sync[NUM_STAGES-1];

endmodule

// File: rtl/pulse_cdc_src.sv
// Source-side launcher for the toggle pulse crossing: queues events, sends one toggle per
// event and waits for its echo. Optional ack watchdog: define PULSE_CDC_SRC_TIMEOUT_EN.
module pulse_cdc_src
    import pulse_cdc_src_pkg::*;
#(
    parameter int NUM_STAGES  = PULSE_CDC_NUM_STAGES,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_in,
    input  logic             ack_toggle_in,
    input  logic             clr_overflow,
    output logic             req_toggle_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("pulse_cdc_src: NUM_STAGES must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("pulse_cdc_src: TIMEOUT_CYC must be at least 1");
    end

    cdc_state_e state;
    logic       ack_edge;
    logic       launch;

    pulse_cdc_ack_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .clk           (clk),
        .reset         (reset),
        .ack_toggle_in (ack_toggle_in),
        .ack_edge      (ack_edge)
    );

    assign launch = (state == IDLE) && (pending_cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            req_toggle_out <= 1'b0;
            busy           <= 1'b0;
            pending_cnt    <= '0;
            overflow       <= 1'b0;
        end else begin
            busy <= (state == WAIT_ACK);

            // An ack edge seen in IDLE is stale or spurious and is deliberately dropped.
            case (state)
                IDLE: begin
                    if (launch) begin
                        req_toggle_out <= ~req_toggle_out;
                        state          <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_edge) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (event_in && !launch) begin
                if (pending_cnt != CNT_MAX) begin
                    pending_cnt <= pending_cnt + 1'b1;
                end
            end else if (!event_in && launch) begin
                pending_cnt <= pending_cnt - 1'b1;
            end

            // Setting takes priority so a drop coinciding with a clear is never lost.
            if (event_in && !launch && (pending_cnt == CNT_MAX)) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef PULSE_CDC_SRC_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;

    // Held at zero in IDLE so every WAIT_ACK entry starts a fresh window; no re-toggle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE || ack_edge) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt      <= '0;
                timeout_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
